// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder sequencer driving one shared external BCD digit slice.
// Optional invalid-digit screening at start is enabled with BCD_SERIAL_CHECK_EN.
module bcd_serial_add_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err,
    output logic [3:0]            dig_a,
    output logic [3:0]            dig_b,
    output logic                  dig_cin,
    input  logic [3:0]            dig_s,
    input  logic                  dig_cout
);

    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [IW-1:0] idx;
    logic          carry;

`ifdef BCD_SERIAL_CHECK_EN
    logic bad_c;

    // Any operand digit above 9 makes the request invalid.
    always_comb begin
        bad_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                bad_c = 1'b1;
            end
        end
    end
`endif

    // Digit pair and carry presented to the shared slice; quiet outside ADD.
    always_comb begin
        dig_a   = 4'd0;
        dig_b   = 4'd0;
        dig_cin = 1'b0;
        if (state == ADD) begin
            dig_a   = a_q[4*int'(idx) +: 4];
            dig_b   = b_q[4*int'(idx) +: 4];
            dig_cin = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        sum   <= '0;
                        cout  <= 1'b0;
                        err   <= 1'b0;
                        carry <= 1'b0;
                        idx   <= '0;
`ifdef BCD_SERIAL_CHECK_EN
                        if (bad_c) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= ADD;
                        end
`else
                        busy  <= 1'b1;
                        state <= ADD;
`endif
                    end
                end
                ADD: begin
                    sum[4*int'(idx) +: 4] <= dig_s;
                    carry <= dig_cout;
                    idx   <= idx + IW'(1);
                    if (idx == LAST) begin
                        cout  <= dig_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl: directed and random additions against a decimal reference.
module tb_bcd_serial_add_ctrl;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    logic [3:0]   dig_a;
    logic [3:0]   dig_b;
    logic         dig_cin;
    logic [3:0]   dig_s;
    logic         dig_cout;

    int checks   = 0;
    int failures = 0;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .err      (err),
        .dig_a    (dig_a),
        .dig_b    (dig_b),
        .dig_cin  (dig_cin),
        .dig_s    (dig_s),
        .dig_cout (dig_cout)
    );

    always #5 clk = ~clk;

    // External single-digit BCD adder slice.
    always_comb begin
        logic [4:0] t;
        t = 5'(dig_a) + 5'(dig_b) + 5'(dig_cin);
        if (t > 5'd9) begin
            dig_s    = 4'(t - 5'd10);
            dig_cout = 1'b1;
        end else begin
            dig_s    = t[3:0];
            dig_cout = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < int'(DIGITS); i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Run one request; invalid=1 means an operand contains a digit above 9.
    task automatic do_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input bit second, input bit invalid);
        int ia, ib, tot, mod;
        int first_done = 0, done_cnt = 0, busy_cnt = 0;
        bit cin_seen = 0, exp_cin_seen = 0, unstable = 0;
        logic [W-1:0] exp_sum, sum_at_done;
        logic         exp_cout, cout_at_done, err_at_done;
        ia  = bcd2int(oa);
        ib  = bcd2int(ob);
        tot = ia + ib;
        exp_sum  = int2bcd(tot % (10 ** DIGITS));
        exp_cout = (tot >= 10 ** DIGITS);
        mod = 1;
        for (int i = 0; i < int'(DIGITS) - 1; i++) begin
            mod = mod * 10;
            if ((ia % mod) + (ib % mod) >= mod) exp_cin_seen = 1;
        end
        sum_at_done = '0; cout_at_done = 0; err_at_done = 0;
        @(negedge clk);
        a = oa; b = ob; start = 1'b1;
        for (int cyc = 1; cyc <= int'(DIGITS) + 8; cyc++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (dig_cin) cin_seen = 1;
            if (done) begin
                done_cnt++;
                if (first_done == 0) begin
                    first_done   = cyc;
                    sum_at_done  = sum;
                    cout_at_done = cout;
                    err_at_done  = err;
                end
            end else if (first_done != 0 && (sum !== sum_at_done || cout !== cout_at_done)) begin
                unstable = 1;
            end
            if (cyc == 1) begin
                start = 1'b0; a = W'($urandom); b = W'($urandom);
            end
            if (second && cyc == 2) begin
                start = 1'b1; a = rand_bcd(); b = rand_bcd();
            end
            if (second && cyc == 3) start = 1'b0;
        end
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_stable"}, 32'(unstable), 32'd0);
`ifdef BCD_SERIAL_CHECK_EN
        if (invalid) begin
            chk({tag, "_latency"}, 32'(first_done), 32'd1);
            chk({tag, "_busy_cyc"}, 32'(busy_cnt), 32'd0);
            chk({tag, "_err"}, 32'(err_at_done), 32'd1);
            chk({tag, "_sum"}, 32'(sum_at_done), 32'd0);
            chk({tag, "_cout"}, 32'(cout_at_done), 32'd0);
            return;
        end
`endif
        chk({tag, "_latency"}, 32'(first_done), 32'(DIGITS + 1));
        chk({tag, "_busy_cyc"}, 32'(busy_cnt), 32'(DIGITS));
        chk({tag, "_err"}, 32'(err_at_done), 32'd0);
        if (!invalid) begin
            chk({tag, "_sum"}, 32'(sum_at_done), 32'(exp_sum));
            chk({tag, "_cout"}, 32'(cout_at_done), 32'(exp_cout));
            chk({tag, "_cin_seen"}, 32'(cin_seen), 32'(exp_cin_seen));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_sum"}, 32'(sum), 32'd0);
        chk({tag, "_cout"}, 32'(cout), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_dig_a"}, 32'(dig_a), 32'd0);
        chk({tag, "_dig_b"}, 32'(dig_b), 32'd0);
        chk({tag, "_dig_cin"}, 32'(dig_cin), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        do_op("basic",  16'h1234, 16'h5678, 1'b0, 1'b0);
        do_op("ripple", 16'h9999, 16'h0001, 1'b0, 1'b0);
        do_op("zero",   16'h0000, 16'h0000, 1'b0, 1'b0);
        do_op("ignore2nd", 16'h1234, 16'h5678, 1'b1, 1'b0);

        // Abort during digit 2 of 0x4567 + 0x5555.
        @(negedge clk);
        a = 16'h4567; b = 16'h5555; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_dig_a", 32'(dig_a), 32'd5);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_reset", 16'h0005, 16'h0005, 1'b0, 1'b0);
        chk("after_reset_val", 32'(sum), 32'h0010);

        do_op("invalid", 16'h12A4, 16'h0000, 1'b0, 1'b1);
        do_op("post_invalid", 16'h0808, 16'h0303, 1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            do_op("rand", rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
